// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Holds the FSM state encoding and the reset values of the result registers.
package mul_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic        RES_VALID_RST = 1'b0;
    localparam logic [63:0] RES_DATA_RST  = 64'd0;
    localparam logic [31:0] RES_ID_RST    = 32'd0;

    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mul_unit.sv
// Purely combinational unsigned multiplier: full 2*WIDTH-bit product, no truncation.
module mul_unit #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] p_o
);

    assign p_o = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among N_REQ requesters (IDLE->EXEC->RESP).
// Optional per-requester saturating grant counters on grant_cnt when MUL_ARB_STATS_EN is defined.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*WIDTH-1:0]        req_a,
    input  logic [N_REQ*WIDTH-1:0]        req_b,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          res_valid,
    output logic [2*WIDTH-1:0]            res_data,
    output logic [mul_arb_pkg::id_w(N_REQ)-1:0] res_id,
    input  logic                          res_ready
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]        grant_cnt
`endif
);

    localparam int ID_W = id_w(N_REQ);

    // Top bit flags "found"; low bits are the winner index, searched from ptr with wrap.
    function automatic logic [ID_W:0] rr_search(input logic [N_REQ-1:0] valid,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W:0]   r;
        logic [ID_W-1:0] idx;
        r = {(ID_W+1){1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            r   = valid[idx] ? {1'b1, idx} : r;
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] res_data_q, res_data_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] prod_s;
    logic [ID_W:0]      win_s;
    logic [N_REQ-1:0]   ready_s;

    assign win_s = rr_search(req_valid, rr_ptr_q);

    mul_unit #(.WIDTH(WIDTH)) u_mul (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod_s)
    );

    // Next-state, operand latch and result registers for the three-phase handshake.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;
        ready_s     = {N_REQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (win_s[ID_W]) begin
                    ready_s[win_s[ID_W-1:0]] = 1'b1;
                    id_d    = win_s[ID_W-1:0];
                    a_d     = req_a[int'(win_s[ID_W-1:0])*WIDTH +: WIDTH];
                    b_d     = req_b[int'(win_s[ID_W-1:0])*WIDTH +: WIDTH];
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                res_data_d  = prod_s;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : id_q + ID_W'(1'b1);
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = RES_VALID_RST;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {ID_W{1'b0}};
            id_q        <= {ID_W{1'b0}};
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_data_q  <= RES_DATA_RST[2*WIDTH-1:0];
            res_id_q    <= RES_ID_RST[ID_W-1:0];
            res_valid_q <= RES_VALID_RST;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_ready = ready_s;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef MUL_ARB_STATS_EN
    logic [N_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating per-requester grant counters, bumped on each accepted handshake.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (ready_s[i] && req_valid[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {(N_REQ*CNT_W){1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: directed scenarios plus a randomized run
// against a transaction-level model. The stats test is built only with MUL_ARB_STATS_EN.
module tb_mul_share_arbiter;

    localparam int N = 4;
    localparam int W = 2;
`ifdef MUL_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [2*W-1:0] res_data;
    logic [1:0]     res_id;
    logic           res_ready;
`ifdef MUL_ARB_STATS_EN
    logic [N*CW-1:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_share_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef MUL_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0h exp=0", res_valid); end
        checks++; if (res_data !== 4'd0) begin failures++; $display("FAIL reset_res_data got=%0h exp=0", res_data); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0h exp=0", res_id); end
        checks++; if (req_ready !== 4'd0) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
        tick; #1;
        checks++; if (req_ready !== 4'd0 || res_valid !== 1'b0) begin
            failures++; $display("FAIL idle_quiet got_ready=%0h got_valid=%0h exp=0", req_ready, res_valid); end
    endtask

    task automatic test_single;
        do_reset;
        req_valid = 4'b0010; req_a = 8'b0000_1100; req_b = 8'b0000_1100; res_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_grant got=%0h exp=2", req_ready); end
        tick;
        req_valid = '0;
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_exec_valid got=%0h exp=0", res_valid); end
        tick; #1;
        checks++; if (res_valid !== 1'b1 || res_data !== 4'd9 || res_id !== 2'd1) begin
            failures++; $display("FAIL single_result got_v=%0h got_d=%0d got_id=%0d exp v=1 d=9 id=1", res_valid, res_data, res_id); end
        tick; #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_done got=%0h exp=0", res_valid); end
    endtask

    task automatic test_round_robin;
        int r, exp_p;
        do_reset;
        req_valid = 4'hF; req_a = 8'($urandom); req_b = 8'($urandom); res_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            r = g % N;
            exp_p = int'(req_a[r*W +: W]) * int'(req_b[r*W +: W]);
            #1;
            checks++; if (req_ready !== 4'(1 << r)) begin
                failures++; $display("FAIL rr_grant%0d got=%0h exp=%0h", g, req_ready, 4'(1 << r)); end
            tick; tick; #1;
            checks++; if (res_valid !== 1'b1 || res_data !== 4'(exp_p) || res_id !== 2'(r)) begin
                failures++; $display("FAIL rr_result%0d got_v=%0h got_d=%0d got_id=%0d exp d=%0d id=%0d", g, res_valid, res_data, res_id, exp_p, r); end
            tick;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        int av, bv;
        do_reset;
        av = $urandom_range(1, 3); bv = $urandom_range(1, 3);
        req_valid = 4'b0100; req_a = 8'(av << 4); req_b = 8'(bv << 4); res_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%0h exp=4", req_ready); end
        tick;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'd0) begin failures++; $display("FAIL bp_exec_ready got=%0h exp=0", req_ready); end
        tick;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (res_valid !== 1'b1 || res_data !== 4'(av * bv) || res_id !== 2'd2 || req_ready !== 4'd0) begin
                failures++; $display("FAIL bp_hold%0d got_v=%0h got_d=%0d got_id=%0d got_rdy=%0h exp d=%0d id=2", c, res_valid, res_data, res_id, req_ready, av * bv); end
            tick;
        end
        res_ready = 1'b1;
        tick; #1;
        checks++; if (res_valid !== 1'b0 || req_ready !== 4'b1000) begin
            failures++; $display("FAIL bp_release got_v=%0h got_rdy=%0h exp v=0 rdy=8", res_valid, req_ready); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_valid = 4'b0001; req_a = 8'd2; req_b = 8'd3; res_ready = 1'b1;
        tick;
        req_valid = '0; rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0h exp=0", res_valid); end
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%0h exp=1", req_ready); end
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            tick; #1;
            checks++; if (res_valid !== 1'b0) begin
                failures++; $display("FAIL midrst_stale%0d got_v=%0h got_d=%0d exp v=0", c, res_valid, res_data); end
        end
    endtask

    task automatic test_random;
        int m_out, m_age, m_id, m_prod, m_ptr, win, idx;
        logic exp_valid;
        logic [N-1:0] exp_ready;
        do_reset;
        m_out = 0; m_age = 0; m_id = 0; m_prod = 0; m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a = 8'($urandom); req_b = 8'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            win = -1;
            if (m_out == 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    idx = (m_ptr + k) % N;
                    if (req_valid[idx]) win = idx;
                end
            end
            exp_ready = (win >= 0) ? 4'(1 << win) : 4'd0;
            exp_valid = (m_out != 0) && (m_age >= 2);
            checks++; if (req_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready cyc=%0d got=%0h exp=%0h", cyc, req_ready, exp_ready); end
            checks++; if (res_valid !== exp_valid) begin
                failures++; $display("FAIL rand_valid cyc=%0d got=%0h exp=%0h", cyc, res_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (res_data !== 4'(m_prod) || res_id !== 2'(m_id)) begin
                    failures++; $display("FAIL rand_result cyc=%0d got_d=%0d got_id=%0d exp d=%0d id=%0d", cyc, res_data, res_id, m_prod, m_id); end
            end
            @(posedge clk);
            if (m_out != 0) begin
                if (exp_valid && res_ready) m_out = 0;
                else m_age++;
            end else if (win >= 0) begin
                m_out = 1; m_age = 1; m_id = win;
                m_prod = int'(req_a[win*W +: W]) * int'(req_b[win*W +: W]);
                m_ptr = (win + 1) % N;
            end
            #1;
        end
        req_valid = '0;
    endtask

`ifdef MUL_ARB_STATS_EN
    task automatic test_stats;
        do_reset;
        req_valid = 4'b0100; req_a = 8'd0; req_b = 8'd0; res_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick;
        checks++; if (grant_cnt[2*CW +: CW] !== 2'd2) begin
            failures++; $display("FAIL stats_partial got=%0d exp=2", grant_cnt[2*CW +: CW]); end
        for (int c = 0; c < 16; c++) tick;
        req_valid = '0;
        checks++; if (grant_cnt[2*CW +: CW] !== 2'd3) begin
            failures++; $display("FAIL stats_saturate got=%0d exp=3", grant_cnt[2*CW +: CW]); end
        checks++; if (grant_cnt[0 +: CW] !== 2'd0 || grant_cnt[CW +: CW] !== 2'd0 || grant_cnt[3*CW +: CW] !== 2'd0) begin
            failures++; $display("FAIL stats_others got=%0h exp=only slot2 set", grant_cnt); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_random;
`ifdef MUL_ARB_STATS_EN
        test_stats;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
